// File: rtl/pm_pkg.sv
// Shared types and helpers for the page-mode arbiter.
package pm_pkg;

   localparam int ADDR_W = 22;
   localparam int LEN_W  = 3;
   localparam int PTR_W  = 2;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE1,
      WAIT1,
      ISSUE2,
      WAIT2,
      DONE
   } pm_state_e;

   // Words left in the page that holds addr, i.e. 2^page_bits - offset.
   function automatic logic [ADDR_W:0] page_room(input logic [ADDR_W-1:0] addr,
                                                 input int page_bits);
      logic [ADDR_W:0] page_sz;
      logic [ADDR_W:0] mask;
      page_sz = (ADDR_W+1)'(1) << page_bits;
      mask    = page_sz - (ADDR_W+1)'(1);
      return page_sz - ({1'b0, addr} & mask);
   endfunction

endpackage

// File: rtl/pm_rr_pick.sv
// Combinational round-robin selector: first request at or after the pointer.
module pm_rr_pick
   import pm_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] rr,
   output logic [NREQ-1:0]  pick,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   logic [PTR_W-1:0] idx_lo;
   logic [PTR_W-1:0] idx_hi;
   logic             hi;

   always_comb begin
      idx_lo = '0;
      idx_hi = '0;
      hi     = 1'b0;
      any    = 1'b0;
      // Descending scan leaves the lowest matching index in each candidate.
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            idx_lo = PTR_W'(j);
            any    = 1'b1;
            if (j >= int'(rr)) begin
               idx_hi = PTR_W'(j);
               hi     = 1'b1;
            end
         end
      end
      idx  = hi ? idx_hi : idx_lo;
      pick = any ? (NREQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/pm_arbiter.sv
// Round-robin arbiter splitting requests into page-safe Page_Mode bursts.
// Optional watchdog enabled by defining PMARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no service; pick and latch a requester
// ISSUE1 | first burst start pulse
// WAIT1  | waiting for first burst completion
// ISSUE2 | second burst start visible (split only)
// WAIT2  | waiting for second burst completion
// DONE   | completion pulse out, return to IDLE
module pm_arbiter
   import pm_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int PAGE_BITS = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                   Clock,
   input  logic                   aReset_n,
   input  logic [NREQ-1:0]        CIN_REQ,
   input  logic [NREQ*ADDR_W-1:0] DIN_ADDR,
   input  logic [NREQ*LEN_W-1:0]  DIN_LEN,
   output logic [NREQ-1:0]        COUT_GNT,
   output logic [NREQ-1:0]        COUT_DONE,
   output logic [ADDR_W-1:0]      DOUT_PM_ADDR,
   output logic [LEN_W-1:0]       DOUT_PM_LEN,
   output logic                   COUT_PM_START,
   input  logic                   CIN_PM_DONE,
   output logic                   COUT_ERR
);

   pm_state_e        state;
   logic [PTR_W-1:0] rr;
   logic [PTR_W-1:0] g_idx;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] room_q;
   logic             split_q;

   logic [NREQ-1:0]   pick;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_any;
   logic [ADDR_W-1:0] sel_addr;
   logic [LEN_W-1:0]  sel_len;
   logic [ADDR_W:0]   room;
   logic [ADDR_W:0]   words;
   logic              split;
   logic [PTR_W-1:0]  rr_next;

   pm_rr_pick #(.NREQ(NREQ)) u_pick (
      .req  (CIN_REQ),
      .rr   (rr),
      .pick (pick),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick_idx == PTR_W'(i)) begin
            sel_addr = DIN_ADDR[i*ADDR_W +: ADDR_W];
            sel_len  = DIN_LEN[i*LEN_W +: LEN_W];
         end
      end
      room  = page_room(sel_addr, PAGE_BITS);
      words = (ADDR_W+1)'(sel_len) + (ADDR_W+1)'(1);
      split = words > room;
   end

   assign rr_next = (g_idx == PTR_W'(NREQ - 1)) ? '0 : g_idx + PTR_W'(1);

`ifdef PMARB_TIMEOUT_EN
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
   logic [7:0] wd_cnt;
`else
   assign COUT_ERR = 1'b0;
`endif

   always_ff @(posedge Clock or negedge aReset_n) begin
      if (!aReset_n) begin
         state         <= IDLE;
         rr            <= '0;
         g_idx         <= '0;
         addr_q        <= '0;
         len_q         <= '0;
         room_q        <= '0;
         split_q       <= 1'b0;
         COUT_GNT      <= '0;
         COUT_DONE     <= '0;
         DOUT_PM_ADDR  <= '0;
         DOUT_PM_LEN   <= '0;
         COUT_PM_START <= 1'b0;
`ifdef PMARB_TIMEOUT_EN
         wd_cnt        <= '0;
         COUT_ERR      <= 1'b0;
`endif
      end else begin
         COUT_PM_START <= 1'b0;
         COUT_DONE     <= '0;
`ifdef PMARB_TIMEOUT_EN
         if (state == WAIT1 || state == WAIT2) wd_cnt <= wd_cnt + 8'd1;
`endif
         case (state)
            IDLE: begin
               if (pick_any) begin
                  COUT_GNT <= pick;
                  g_idx    <= pick_idx;
                  addr_q   <= sel_addr;
                  len_q    <= sel_len;
                  room_q   <= room[LEN_W-1:0];
                  split_q  <= split;
                  state    <= ISSUE1;
               end
            end
            ISSUE1: begin
               COUT_PM_START <= 1'b1;
               DOUT_PM_ADDR  <= addr_q;
               DOUT_PM_LEN   <= split_q ? room_q - LEN_W'(1) : len_q;
`ifdef PMARB_TIMEOUT_EN
               wd_cnt        <= '0;
`endif
               state         <= WAIT1;
            end
            WAIT1: begin
               if (CIN_PM_DONE) begin
                  if (split_q) begin
                     // Second start is registered here so it follows the engine done by one cycle.
                     COUT_PM_START <= 1'b1;
                     DOUT_PM_ADDR  <= addr_q + ADDR_W'(room_q);
                     DOUT_PM_LEN   <= len_q - room_q;
`ifdef PMARB_TIMEOUT_EN
                     wd_cnt        <= '0;
`endif
                     state         <= ISSUE2;
                  end else begin
                     COUT_DONE <= COUT_GNT;
                     COUT_GNT  <= '0;
                     rr        <= rr_next;
                     state     <= DONE;
                  end
               end
`ifdef PMARB_TIMEOUT_EN
               else if (wd_cnt == WD_LIMIT) begin
                  COUT_ERR  <= 1'b1;
                  COUT_DONE <= COUT_GNT;
                  COUT_GNT  <= '0;
                  rr        <= rr_next;
                  state     <= DONE;
               end
`endif
            end
            ISSUE2: state <= WAIT2;
            WAIT2: begin
               if (CIN_PM_DONE) begin
                  COUT_DONE <= COUT_GNT;
                  COUT_GNT  <= '0;
                  rr        <= rr_next;
                  state     <= DONE;
               end
`ifdef PMARB_TIMEOUT_EN
               else if (wd_cnt == WD_LIMIT) begin
                  COUT_ERR  <= 1'b1;
                  COUT_DONE <= COUT_GNT;
                  COUT_GNT  <= '0;
                  rr        <= rr_next;
                  state     <= DONE;
               end
`endif
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pm_arbiter.sv
// Directed bench for pm_arbiter with a start/done scoreboard and a simple engine model.
module tb_pm_arbiter;

   localparam int NREQ = 2;
`ifdef PMARB_TIMEOUT_EN
   localparam int TMO = 20;
`else
   localparam int TMO = 255;
`endif

   logic        Clock = 1'b0;
   logic        aReset_n = 1'b0;
   logic [1:0]  CIN_REQ = '0;
   logic [43:0] DIN_ADDR = '0;
   logic [5:0]  DIN_LEN = '0;
   logic        CIN_PM_DONE = 1'b0;
   logic [1:0]  COUT_GNT;
   logic [1:0]  COUT_DONE;
   logic [21:0] DOUT_PM_ADDR;
   logic [2:0]  DOUT_PM_LEN;
   logic        COUT_PM_START;
   logic        COUT_ERR;

   pm_arbiter #(.NREQ(NREQ), .PAGE_BITS(4), .TIMEOUT(TMO)) dut (
      .Clock         (Clock),
      .aReset_n      (aReset_n),
      .CIN_REQ       (CIN_REQ),
      .DIN_ADDR      (DIN_ADDR),
      .DIN_LEN       (DIN_LEN),
      .COUT_GNT      (COUT_GNT),
      .COUT_DONE     (COUT_DONE),
      .DOUT_PM_ADDR  (DOUT_PM_ADDR),
      .DOUT_PM_LEN   (DOUT_PM_LEN),
      .COUT_PM_START (COUT_PM_START),
      .CIN_PM_DONE   (CIN_PM_DONE),
      .COUT_ERR      (COUT_ERR)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [21:0] addr;
      logic [2:0]  len;
      logic [1:0]  gnt;
   } start_t;

   start_t     start_q[$];
   logic [1:0] done_q[$];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_start(input logic [21:0] a, input logic [2:0] l, input logic [1:0] g);
      start_q.push_back(start_t'{addr: a, len: l, gnt: g});
   endtask

   task automatic set_req(input int i, input logic [21:0] a, input logic [2:0] l);
      DIN_ADDR[i*22 +: 22] = a;
      DIN_LEN[i*3 +: 3]    = l;
      CIN_REQ[i]           = 1'b1;
   endtask

   task automatic wait_start();
      int t;
      t = 0;
      while (!COUT_PM_START && t < 30) begin
         @(negedge Clock);
         t++;
      end
      check("start_timeout", 32'(COUT_PM_START), 1);
   endtask

   // Engine model: acknowledge each burst a few cycles after its start.
   task automatic engine(input int nb, input logic [1:0] gexp);
      for (int b = 0; b < nb; b++) begin
         wait_start();
         repeat (3) @(negedge Clock);
         check("gnt_hold", 32'(COUT_GNT), 32'(gexp));
         CIN_PM_DONE = 1'b1;
         @(negedge Clock);
         CIN_PM_DONE = 1'b0;
         if (b < nb - 1) begin
            check("split_start_lat", 32'(COUT_PM_START), 1);
         end else begin
            check("done_lat", 32'(COUT_DONE), 32'(gexp));
            check("gnt_drop", 32'(COUT_GNT), 0);
         end
      end
   endtask

   always @(negedge Clock) begin
      start_t e;
      if (aReset_n && COUT_PM_START) begin
         check("start_expected", 32'(start_q.size() != 0), 1);
         if (start_q.size() != 0) begin
            e = start_q.pop_front();
            check("start_addr", 32'(DOUT_PM_ADDR), 32'(e.addr));
            check("start_len", 32'(DOUT_PM_LEN), 32'(e.len));
            check("start_gnt", 32'(COUT_GNT), 32'(e.gnt));
         end
      end
      if (aReset_n && (|COUT_DONE)) begin
         check("done_expected", 32'(done_q.size() != 0), 1);
         if (done_q.size() != 0) check("done_vec", 32'(COUT_DONE), 32'(done_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
`ifdef PMARB_TIMEOUT_EN
      int n;
`endif
      #1;
      check("rst_gnt", 32'(COUT_GNT), 0);
      check("rst_done", 32'(COUT_DONE), 0);
      check("rst_addr", 32'(DOUT_PM_ADDR), 0);
      check("rst_len", 32'(DOUT_PM_LEN), 0);
      check("rst_start", 32'(COUT_PM_START), 0);
      check("rst_err", 32'(COUT_ERR), 0);
      repeat (2) @(negedge Clock);
      aReset_n = 1'b1;
      @(negedge Clock);

      // Single burst: whole 16-word-aligned 8-word read.
      push_start(22'h000000, 3'd7, 2'b01);
      done_q.push_back(2'b01);
      set_req(0, 22'h000000, 3'd7);
      @(negedge Clock);
      check("gnt_lat", 32'(COUT_GNT), 32'b01);
      check("start_not_yet", 32'(COUT_PM_START), 0);
      @(negedge Clock);
      check("start_lat", 32'(COUT_PM_START), 1);
      engine(1, 2'b01);
      CIN_REQ[0] = 1'b0;
      @(negedge Clock);

      // Page split: 0xC + 8 words crosses into the next page at 0x10.
      push_start(22'h00000C, 3'd3, 2'b01);
      push_start(22'h000010, 3'd3, 2'b01);
      done_q.push_back(2'b01);
      set_req(0, 22'h00000C, 3'd7);
      engine(2, 2'b01);
      CIN_REQ[0] = 1'b0;
      @(negedge Clock);

      // Address wrap at the top of the 22-bit space.
      push_start(22'h3FFFFE, 3'd1, 2'b10);
      push_start(22'h000000, 3'd1, 2'b10);
      done_q.push_back(2'b10);
      set_req(1, 22'h3FFFFE, 3'd3);
      engine(2, 2'b10);
      CIN_REQ[1] = 1'b0;

      // Stray engine done while idle must not produce anything.
      repeat (3) @(negedge Clock);
      CIN_PM_DONE = 1'b1;
      @(negedge Clock);
      CIN_PM_DONE = 1'b0;
      repeat (3) @(negedge Clock);
      check("idle_gnt", 32'(COUT_GNT), 0);
      check("idle_start", 32'(COUT_PM_START), 0);

      // Round robin with both requesters held high; pointer is 0 here.
      push_start(22'h000100, 3'd1, 2'b01);
      done_q.push_back(2'b01);
      push_start(22'h000205, 3'd2, 2'b10);
      done_q.push_back(2'b10);
      push_start(22'h000100, 3'd1, 2'b01);
      done_q.push_back(2'b01);
      set_req(0, 22'h000100, 3'd1);
      set_req(1, 22'h000205, 3'd2);
      engine(1, 2'b01);
      engine(1, 2'b10);
      engine(1, 2'b01);
      CIN_REQ = '0;
      repeat (2) @(negedge Clock);

      // Reset in WAIT1 of requester 1's transfer; no completion may follow.
      push_start(22'h000040, 3'd2, 2'b10);
      set_req(1, 22'h000040, 3'd2);
      wait_start();
      repeat (2) @(negedge Clock);
      aReset_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(COUT_GNT), 0);
      check("mid_rst_addr", 32'(DOUT_PM_ADDR), 0);
      check("mid_rst_len", 32'(DOUT_PM_LEN), 0);
      check("mid_rst_start", 32'(COUT_PM_START), 0);
      check("mid_rst_done", 32'(COUT_DONE), 0);
      CIN_REQ = '0;
      repeat (2) @(negedge Clock);
      aReset_n = 1'b1;
      repeat (3) @(negedge Clock);
      check("post_rst_idle", 32'(COUT_GNT), 0);

      // Pointer restarts at requester 0 after reset.
      push_start(22'h000080, 3'd0, 2'b01);
      done_q.push_back(2'b01);
      set_req(0, 22'h000080, 3'd0);
      set_req(1, 22'h000090, 3'd0);
      engine(1, 2'b01);
      CIN_REQ = '0;
      repeat (3) @(negedge Clock);

`ifdef PMARB_TIMEOUT_EN
      push_start(22'h000030, 3'd0, 2'b01);
      done_q.push_back(2'b01);
      set_req(0, 22'h000030, 3'd0);
      wait_start();
      n = 0;
      while (COUT_DONE == 2'b00 && n < 40) begin
         @(negedge Clock);
         n++;
      end
      check("wd_latency", 32'(n), 21);
      check("wd_err", 32'(COUT_ERR), 1);
      CIN_REQ = '0;
      repeat (5) @(negedge Clock);
      check("wd_err_sticky", 32'(COUT_ERR), 1);
`else
      check("err_tied", 32'(COUT_ERR), 0);
`endif

      check("start_q_empty", 32'(start_q.size()), 0);
      check("done_q_empty", 32'(done_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
